// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter: bus stores fill a small TX FIFO and an
// FSM serialises the bytes LSB first on tx_o. STATUS is polled through ReadData_o.
module uart_tx_periph #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Sel_i,
    input  logic [DATA_WIDTH-1:0] Address_i,
    input  logic [DATA_WIDTH-1:0] WriteData_i,
    input  logic                  MemWrite_i,
    output logic [DATA_WIDTH-1:0] ReadData_o,
    output logic                  tx_o,
    output logic                  busy_o
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_d;
    logic              pop_c;

    logic [7:0]        fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              overflow_q;

    logic full_c, empty_c, bit_end_c;
    logic push_req_c, push_c, stat_wr_c;
    logic unused_bits;

    assign full_c     = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty_c    = (count_q == '0);
    assign bit_end_c  = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
    assign push_req_c = Sel_i & MemWrite_i & ~Address_i[2];
    assign stat_wr_c  = Sel_i & MemWrite_i & Address_i[2];
    // A full FIFO still accepts a push when the FSM pops in the same cycle.
    assign push_c     = push_req_c & (~full_c | pop_c);

    assign unused_bits = ^{Address_i[DATA_WIDTH-1:3], Address_i[1:0],
                           WriteData_i[DATA_WIDTH-1:8]};

    assign ReadData_o = (Sel_i & Address_i[2])
                      ? DATA_WIDTH'({overflow_q, empty_c, full_c, busy_o})
                      : '0;

    // Next-state and datapath for the serialiser
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        pop_c     = 1'b0;
        tx_d      = 1'b1;

        if (state_q != S_IDLE) begin
            baud_d = bit_end_c ? '0 : baud_q + BAUD_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (!empty_c) begin
                    pop_c     = 1'b1;
                    shift_d   = fifo_mem[rd_ptr_q];
                    baud_d    = '0;
                    bit_idx_d = '0;
                    state_d   = S_START;
                end
            end
            S_START: begin
                if (bit_end_c) begin
                    bit_idx_d = '0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end_c) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (bit_end_c) begin
                    // Chain straight into the next start bit when more data waits.
                    if (!empty_c) begin
                        pop_c     = 1'b1;
                        shift_d   = fifo_mem[rd_ptr_q];
                        bit_idx_d = '0;
                        state_d   = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_o      <= 1'b1;
            busy_o    <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_o      <= tx_d;
            busy_o    <= (state_d != S_IDLE);
        end
    end

    // FIFO bookkeeping and sticky overflow (a set beats a clear)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(push_c) - CNT_W'(pop_c);
            if (push_req_c && !push_c) begin
                overflow_q <= 1'b1;
            end else if (stat_wr_c && WriteData_i[3]) begin
                overflow_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_c) begin
            fifo_mem[wr_ptr_q] <= WriteData_i[7:0];
        end
    end

endmodule

// File: tb/tb_uart_tx_periph.sv
// Directed bench for uart_tx_periph: frame shape, back-to-back, overflow,
// mid-frame reset and address decode, all against hand-derived values.
module tb_uart_tx_periph;

    localparam int unsigned DW    = 32;
    localparam int unsigned CPB   = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned FRAME = 10 * CPB;

    logic          clk;
    logic          reset;
    logic          sel;
    logic          mem_write;
    logic [DW-1:0] address;
    logic [DW-1:0] write_data;
    logic [DW-1:0] read_data;
    logic          tx;
    logic          busy;

    int n_checks = 0;
    int n_errors = 0;

    bit         rec = 1'b0;
    bit         tx_log[$];
    bit         busy_log[$];
    logic [7:0] exp_bytes[$];

    uart_tx_periph #(
        .DATA_WIDTH  (DW),
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .Sel_i      (sel),
        .Address_i  (address),
        .WriteData_i(write_data),
        .MemWrite_i (mem_write),
        .ReadData_o (read_data),
        .tx_o       (tx),
        .busy_o     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One sample per cycle, shortly after the active edge
    always @(posedge clk) begin
        #2;
        if (rec) begin
            tx_log.push_back(tx);
            busy_log.push_back(busy);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_bus();
        sel        = 1'b0;
        mem_write  = 1'b0;
        address    = '0;
        write_data = '0;
    endtask

    task automatic drive_write(input logic [DW-1:0] addr, input logic [DW-1:0] data);
        sel        = 1'b1;
        mem_write  = 1'b1;
        address    = addr;
        write_data = data;
    endtask

    task automatic write1(input logic [DW-1:0] addr, input logic [DW-1:0] data);
        drive_write(addr, data);
        @(negedge clk);
        idle_bus();
    endtask

    task automatic check_status(input string tag, input logic [DW-1:0] exp);
        sel       = 1'b1;
        mem_write = 1'b0;
        address   = 32'h4;
        #1;
        check(tag, read_data, exp);
        idle_bus();
    endtask

    task automatic start_log();
        tx_log.delete();
        busy_log.delete();
        rec = 1'b1;
    endtask

    // Log index 0 is the cycle of the first write; frames must follow contiguously.
    task automatic check_frames(input string tag);
        int          need;
        int          cyc;
        int          base;
        logic [63:0] exp_v;
        logic [63:0] obs_v;
        logic [63:0] bsy_v;
        logic [7:0]  b;
        need = 1 + FRAME * exp_bytes.size() + 2;
        cyc  = 0;
        while (tx_log.size() < need && cyc < 4000) begin
            @(negedge clk);
            cyc++;
        end
        rec = 1'b0;
        if (tx_log.size() < need) begin
            check({tag, "_log"}, 64'(tx_log.size()), 64'(need));
            return;
        end
        check({tag, "_pre"}, {62'd0, tx_log[0], busy_log[0]}, 64'b10);
        for (int f = 0; f < exp_bytes.size(); f++) begin
            b     = exp_bytes[f];
            exp_v = '0;
            obs_v = '0;
            bsy_v = '0;
            base  = 1 + f * FRAME;
            for (int i = 0; i < FRAME; i++) begin
                int bit_n;
                bit_n = i / CPB;
                if (bit_n == 0)      exp_v[i] = 1'b0;
                else if (bit_n == 9) exp_v[i] = 1'b1;
                else                 exp_v[i] = b[bit_n-1];
                obs_v[i] = tx_log[base+i];
                bsy_v[i] = busy_log[base+i];
            end
            check($sformatf("%s_f%0d_tx", tag, f), obs_v, exp_v);
            check($sformatf("%s_f%0d_busy", tag, f), bsy_v, {24'd0, 40'hFF_FFFF_FFFF});
        end
        base = 1 + FRAME * exp_bytes.size();
        check({tag, "_post0"}, {62'd0, tx_log[base], busy_log[base]}, 64'b10);
        check({tag, "_post1"}, {62'd0, tx_log[base+1], busy_log[base+1]}, 64'b10);
    endtask

    initial begin
        logic [9:0] a5_seq;
        logic [9:0] a5_obs;
        int         lows;
        int         busys;
        reset = 1'b0;
        idle_bus();
        repeat (3) @(negedge clk);
        check("rst_line", {62'd0, tx, busy}, 64'b10);
        check_status("rst_status", 32'h4);
        reset = 1'b1;
        @(negedge clk);
        check("idle_line", {62'd0, tx, busy}, 64'b10);

        // Single byte 0xA5
        start_log();
        write1(32'h0, 32'h0000_00A5);
        exp_bytes.delete();
        exp_bytes.push_back(8'hA5);
        check_frames("single");
        a5_seq = 10'b11_0100_1010;
        a5_obs = '0;
        if (tx_log.size() > FRAME) begin
            for (int k = 0; k < 10; k++) a5_obs[k] = tx_log[1 + k*CPB + CPB/2];
        end
        check("a5_levels", 64'(a5_obs), 64'(a5_seq));

        // Back-to-back 0x55, 0x0F
        start_log();
        drive_write(32'h0, 32'h55);
        @(negedge clk);
        drive_write(32'h0, 32'h0F);
        @(negedge clk);
        idle_bus();
        exp_bytes.delete();
        exp_bytes.push_back(8'h55);
        exp_bytes.push_back(8'h0F);
        check_frames("b2b");

        // Six consecutive writes: fill to 4 and drop the sixth
        begin
            logic [DW-1:0] st_exp [6];
            st_exp = '{32'h0, 32'h1, 32'h1, 32'h1, 32'h3, 32'hB};
            start_log();
            for (int i = 0; i < 6; i++) begin
                drive_write(32'h0, 32'(8'h10 + i));
                @(negedge clk);
                check_status($sformatf("ovf_st%0d", i), st_exp[i]);
            end
            idle_bus();
        end
        exp_bytes.delete();
        for (int i = 0; i < 5; i++) exp_bytes.push_back(8'(8'h10 + i));
        check_frames("ovf");
        check_status("ovf_idle_st", 32'hC);

        // Overflow clear only via bit 3
        write1(32'h4, 32'h7);
        check_status("ovf_noclr", 32'hC);
        write1(32'h4, 32'h8);
        check_status("ovf_clr", 32'h4);

        // Reset during DATA bit 3 of 0x3C with two bytes queued
        drive_write(32'h0, 32'h3C);
        @(negedge clk);
        drive_write(32'h0, 32'h11);
        @(negedge clk);
        drive_write(32'h0, 32'h22);
        @(negedge clk);
        idle_bus();
        repeat (16) @(negedge clk);
        check("mid_busy", {63'd0, busy}, 64'd1);
        check_status("mid_st", 32'h1);
        reset = 1'b0;
        #1;
        check("mid_rst_line", {62'd0, tx, busy}, 64'b10);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_status("mid_rel_st", 32'h4);
        start_log();
        repeat (50) @(negedge clk);
        rec   = 1'b0;
        lows  = 0;
        busys = 0;
        foreach (tx_log[i]) begin
            if (!tx_log[i])  lows++;
            if (busy_log[i]) busys++;
        end
        check("mid_quiet_samples", 64'(tx_log.size() >= 45), 64'd1);
        check("mid_quiet_tx", 64'(lows), 64'd0);
        check("mid_quiet_busy", 64'(busys), 64'd0);

        start_log();
        write1(32'h0, 32'h81);
        exp_bytes.delete();
        exp_bytes.push_back(8'h81);
        check_frames("post_rst");

        // Address decode
        sel        = 1'b0;
        mem_write  = 1'b1;
        address    = 32'h4;
        write_data = 32'hF;
        #1;
        check("dec_nosel_st", read_data, 32'h0);
        @(negedge clk);
        address    = 32'h0;
        write_data = 32'hAA;
        #1;
        check("dec_nosel_tx", read_data, 32'h0);
        @(negedge clk);
        idle_bus();
        sel = 1'b1;
        #1;
        check("dec_txdata_rd", read_data, 32'h0);
        idle_bus();
        @(negedge clk);
        @(negedge clk);
        check_status("dec_fifo_st", 32'h4);
        check("dec_line", {62'd0, tx, busy}, 64'b10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_periph.md
Name: uart_tx_periph

Overview:
Memory-mapped UART transmitter peripheral. It sits on the peripheral side of the core's memory controller, alongside the GPIO output register, and consumes the same Address/WriteData/MemWrite bus the controller routes to GPIO. Stores to the data register push bytes into a small FIFO. An FSM serialises the bytes as 8N1 frames on tx_o. Status is returned through ReadData_o for polling by software.

Parameters:
DATA_WIDTH, 32, bus data/address width
CLKS_PER_BIT, 16, clock cycles per UART bit; legal values >= 2
FIFO_DEPTH, 4, TX FIFO entries; power of 2, >= 2

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
Sel_i  input  1  peripheral select from the memory controller address decode
Address_i  input  DATA_WIDTH  bus address; only bit 2 decoded (0 = TXDATA, 1 = STATUS)
WriteData_i  input  DATA_WIDTH  store data
MemWrite_i  input  1  store strobe
ReadData_o  output  DATA_WIDTH  combinational read data
tx_o  output  1  serial line, idle high
busy_o  output  1  1 while the FSM is not in IDLE

Behaviour:
- Reset (reset = 0, asynchronous):
  - FIFO emptied; overflow flag cleared; FSM to IDLE.
  - Baud counter and bit counter cleared.
  - tx_o = 1, busy_o = 0.
  - Effect is immediate, including mid-frame.
- Push:
  - A push request occurs on a rising edge with Sel_i & MemWrite_i & ~Address_i[2]; the pushed byte is WriteData_i[7:0].
  - The push is accepted if count < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and the overflow flag is set.
- Simultaneous push and pop: count unchanged, data order preserved.
- STATUS write (Sel_i & MemWrite_i & Address_i[2]):
  - WriteData_i[3] = 1 clears overflow.
  - If a set and a clear of overflow occur in the same cycle, set wins.
  - No other bits are writable.
- ReadData_o (combinational):
  - Sel_i & Address_i[2]: {28'b0, overflow, empty, full, busy} in bits [3:0].
  - Sel_i & ~Address_i[2]: 0.
  - ~Sel_i: 0.
- FSM states: IDLE, START, DATA, STOP.
  - A 0..CLKS_PER_BIT-1 baud counter runs in every non-IDLE state; a bit "ends" when it reaches CLKS_PER_BIT-1.
  - IDLE: tx_o = 1. If the FIFO is non-empty, pop the head into an 8-bit shift register, clear the counters, and go to START.
  - START: tx_o = 0. At bit end, go to DATA with bit index 0.
  - DATA: tx_o = shift[0] (LSB first). At each bit end, shift right and increment the index. After index 7 ends, go to STOP.
  - STOP: tx_o = 1. At bit end, if the FIFO is non-empty, pop and go directly to START (back-to-back frames, no idle gap). Otherwise go to IDLE.
- Timing:
  - Frame length is exactly 10*CLKS_PER_BIT cycles.
  - For a write at edge N into an empty FIFO in IDLE, the pop and tx_o falling occur at edge N+1.
  - busy_o is 1 from edge N+1 until the final STOP bit end without a further pop.
- FIFO pointers wrap modulo FIFO_DEPTH. The count is held in log2(FIFO_DEPTH)+1 bits.
- full = (count == FIFO_DEPTH); empty = (count == 0).
- tx_o is driven from a flop; it is glitch-free.

Test Plan:
- Single byte (CLKS_PER_BIT = 4): after reset, write 0x000000A5 to TXDATA.
  - Response: tx_o = 0,1,0,1,0,0,1,0,1,1, each level held for 4 cycles, starting the cycle after the write edge.
  - busy_o = 1 for exactly 40 cycles, then tx_o = 1 and busy_o = 0.
- Back-to-back: write 0x55 then 0x0F on consecutive cycles.
  - Response: two frames totalling 80 cycles.
  - The second start bit begins on the cycle immediately after the first stop bit ends; busy_o never drops between frames.
- Overflow (FIFO_DEPTH = 4): write 6 bytes on 6 consecutive cycles from idle.
  - Count after the writes is 1,1,2,3,4; the 6th write is dropped.
  - STATUS read returns 0x0000000B.
  - Only the first 5 bytes appear on tx_o, in order.
- Overflow clear: after the previous scenario, write 0x8 to STATUS.
  - STATUS bit3 = 0 on the next read.
  - When a dropped push and a clear occur in the same cycle, bit3 = 1.
- Reset mid-frame: assert reset during DATA bit 3 of byte 0x3C, with 2 bytes queued.
  - Response: tx_o = 1 and busy_o = 0 immediately.
  - STATUS = 0x00000004 after release.
  - No frame is emitted until a new write.
- Decode: with Sel_i = 0, MemWrite_i = 1, and STATUS selected by address, the FIFO is unchanged and ReadData_o = 0. With Sel_i = 1 and Address_i[2] = 0, ReadData_o = 0.
